// File: rtl/fpu_lzc_pkg.sv
// ---------------------------------------------------------------------------
// fpu_lzc_pkg
//   Shared types and elaboration helpers for the pipelined leading/trailing
//   zero counter used on the FPU normalisation path.
//
//   lzc_mode_t  : scan direction selector (lead = from MSB, trail = from LSB)
//   lzc_levels  : number of merge-tree levels for a given operand width
//   lzc_stages  : number of register stages for a given width / levels-per-stage
// ---------------------------------------------------------------------------
package fpu_lzc_pkg;

  typedef enum logic {
    LZC_LEAD  = 1'b0,
    LZC_TRAIL = 1'b1
  } lzc_mode_t;

  // One tree level per halving of the operand: the leaf level consumes bit
  // pairs, every later level merges two nodes of the level below.
  function automatic int lzc_levels(input int width);
    return $clog2(width);
  endfunction

  // Every REG_EVERY levels close a stage; a partial group at the root still
  // gets its own register, hence the ceiling division.
  function automatic int lzc_stages(input int width, input int reg_every);
    return (lzc_levels(width) + reg_every - 1) / reg_every;
  endfunction

endpackage

// File: rtl/lzc_merge.sv
// ---------------------------------------------------------------------------
// lzc_merge
//   Purely combinational merge of two adjacent zero-count nodes. The left
//   node covers the more significant half of the span, the right node the
//   less significant half; both halves hold 2**CW bits.
//
//   cnt_left   in  CW    zero count of the MSB half
//   zeros_left in  1     MSB half is all zeros
//   cnt_right  in  CW    zero count of the LSB half
//   zeros_right in 1     LSB half is all zeros
//   cnt        out CW+1  zero count of the merged span
//   zeros      out 1     merged span is all zeros
// ---------------------------------------------------------------------------
module lzc_merge
  import fpu_lzc_pkg::*;
#(
  parameter int CW = 1
) (
  input  logic [CW-1:0] cnt_left,
  input  logic          zeros_left,
  input  logic [CW-1:0] cnt_right,
  input  logic          zeros_right,
  output logic [CW:0]   cnt,
  output logic          zeros
);

  always_comb begin
    zeros = zeros_left & zeros_right;
    if (!zeros_left) begin
      cnt = {1'b0, cnt_left};
    end else if (!zeros_right) begin
      // The whole left half (2**CW zeros) precedes the first one on the right.
      cnt = {1'b1, cnt_right};
    end else begin
      // An all-zero span reports count 0; the root substitutes WIDTH.
      cnt = '0;
    end
  end

endmodule

// File: rtl/lzc_pipelined.sv
// ---------------------------------------------------------------------------
// lzc_pipelined
//   Pipelined leading/trailing zero counter. A log2(WIDTH)-level merge tree
//   is cut by a register bank after every REG_EVERY levels (and after the
//   root). Each stage has a valid bit; a stage accepts a new beat whenever it
//   is empty or its content moves on, so bubbles collapse even while the
//   output is stalled. A sideband tag travels alongside the data.
//
//   clk        in   1              clock
//   reset      in   1              synchronous, active-high reset
//   in_valid   in   1              input beat valid
//   in_ready   out  1              a beat is accepted this cycle if in_valid
//   in_data    in   WIDTH          operand to scan
//   in_mode    in   1              0 = leading zeros, 1 = trailing zeros
//   in_tag     in   TAG_W          opaque sideband returned with the result
//   out_valid  out  1              result valid
//   out_ready  in   1              downstream accepts the result
//   out_count  out  log2(WIDTH)+1  zero count, 0..WIDTH
//   out_zero   out  1              operand was all zeros
//   out_tag    out  TAG_W          tag of this result
// ---------------------------------------------------------------------------
module lzc_pipelined
  import fpu_lzc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH):0]   out_count,
  output logic                     out_zero,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int LEVELS = lzc_levels(WIDTH);
  localparam int STAGES = lzc_stages(WIDTH, REG_EVERY);

  genvar gi, ni;

  // -------------------------------------------------------------------------
  // Flow control
  // -------------------------------------------------------------------------
  logic [STAGES-1:0] v_reg;          // stage holds a live beat
  logic [STAGES-1:0] stage_ready;    // stage register will load this cycle
  logic [STAGES-1:0] stage_in_valid; // beat presented to the stage input
  logic [STAGES-1:0] stage_load;     // stage captures a live beat
  logic              ready_acc;

  // A stage can load if it or any stage downstream of it is empty, or the
  // output is being drained. Walking from the output back towards the input
  // keeps this a plain OR-chain with no feedback through stage_ready itself.
  always_comb begin
    ready_acc   = out_ready;
    stage_ready = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      ready_acc      = ready_acc | ~v_reg[i];
      stage_ready[i] = ready_acc;
    end
  end

  assign stage_load = stage_ready & stage_in_valid;
  assign in_ready   = stage_ready[0];
  assign out_valid  = v_reg[STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      v_reg <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (stage_ready[i]) begin
          v_reg[i] <= stage_in_valid[i];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Tag delay line, one register per stage, moving in lockstep with the data
  // -------------------------------------------------------------------------
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [TAG_W-1:0] tag_in;
    logic [TAG_W-1:0] tag_reg;

    if (gi == 0) begin : g_head
      assign stage_in_valid[gi] = in_valid;
      assign tag_in             = in_tag;
    end else begin : g_body
      assign stage_in_valid[gi] = v_reg[gi-1];
      assign tag_in             = g_stage[gi-1].tag_reg;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        tag_reg <= '0;
      end else if (stage_load[gi]) begin
        tag_reg <= tag_in;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Tree entry: trailing-zero mode is leading-zero counting on the mirrored
  // operand, so the rest of the tree is mode-agnostic.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] data_rev;
  logic [WIDTH-1:0] entry_data;

  for (gi = 0; gi < WIDTH; gi++) begin : g_rev
    assign data_rev[gi] = in_data[WIDTH-1-gi];
  end

  assign entry_data = (lzc_mode_t'(in_mode) == LZC_TRAIL) ? data_rev : in_data;

  // -------------------------------------------------------------------------
  // Merge tree. Level gi has WIDTH>>gi nodes, each with a gi-bit count and an
  // all-zero flag. Node ni of a level covers the span just above node ni-1,
  // so node 2*ni+1 of the level below is the MSB-side (left) child of node ni.
  // -------------------------------------------------------------------------
  for (gi = 1; gi <= LEVELS; gi++) begin : g_lvl
    localparam int  NODES    = WIDTH >> gi;
    localparam bit  REG_HERE = ((gi % REG_EVERY) == 0) || (gi == LEVELS);

    logic [NODES*gi-1:0] cnt_next;
    logic [NODES-1:0]    zeros_next;
    logic [NODES*gi-1:0] cnt_out;
    logic [NODES-1:0]    zeros_out;

    if (gi == 1) begin : g_leaf
      for (ni = 0; ni < NODES; ni++) begin : g_node
        assign zeros_next[ni] = ~entry_data[2*ni+1] & ~entry_data[2*ni];
        assign cnt_next[ni]   = ~entry_data[2*ni+1];
      end
    end else begin : g_merge
      for (ni = 0; ni < NODES; ni++) begin : g_node
        lzc_merge #(
          .CW (gi - 1)
        ) u_merge (
          .cnt_left    (g_lvl[gi-1].cnt_out[(2*ni+1)*(gi-1) +: (gi-1)]),
          .zeros_left  (g_lvl[gi-1].zeros_out[2*ni+1]),
          .cnt_right   (g_lvl[gi-1].cnt_out[(2*ni)*(gi-1) +: (gi-1)]),
          .zeros_right (g_lvl[gi-1].zeros_out[2*ni]),
          .cnt         (cnt_next[ni*gi +: gi]),
          .zeros       (zeros_next[ni])
        );
      end
    end

    if (REG_HERE) begin : g_reg
      // Level gi closes stage (gi-1)/REG_EVERY; the root closes the last one.
      localparam int STG = (gi - 1) / REG_EVERY;

      logic [NODES*gi-1:0] cnt_reg;
      logic [NODES-1:0]    zeros_reg;

      // Loads only on a live beat so undriven inputs never enter the pipe.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg   <= '0;
          zeros_reg <= '0;
        end else if (stage_load[STG]) begin
          cnt_reg   <= cnt_next;
          zeros_reg <= zeros_next;
        end
      end

      assign cnt_out   = cnt_reg;
      assign zeros_out = zeros_reg;
    end else begin : g_comb
      assign cnt_out   = cnt_next;
      assign zeros_out = zeros_next;
    end
  end

  // -------------------------------------------------------------------------
  // Root: the tree reports 0 for an all-zero span, which becomes WIDTH here.
  // Both root and tag sit in last-stage registers, so they hold while stalled.
  // -------------------------------------------------------------------------
  assign out_zero  = g_lvl[LEVELS].zeros_out[0];
  assign out_count = out_zero ? (LEVELS+1)'(WIDTH)
                              : {1'b0, g_lvl[LEVELS].cnt_out};
  assign out_tag   = g_stage[STAGES-1].tag_reg;

endmodule
